// File: rtl/sipo_deser.sv
// MSB-first serial-to-parallel deserializer with valid/ack handoff and sticky overrun flag.
// Optional SIPO_PARITY_EN: each frame gains a trailing even-parity bit, checked into parity_err.
module sipo_deser #(
    parameter  int WIDE = 4,
    localparam int CW   = $clog2(WIDE + 2)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sh,
    input  logic            din,
    input  logic            ack,
    output logic [WIDE-1:0] dout,
    output logic            valid,
    output logic            overrun,
    output logic [CW-1:0]   bit_cnt,
    output logic            parity_err
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR} state_t;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDE - 1);

    state_t            state, state_next;
    logic [WIDE-1:0]   sr, sr_next, shifted, word;
    logic [CW-1:0]     cnt_next;
    logic              done;

    assign shifted = {sr[WIDE-2:0], din};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        sr_next    = sr;
        done       = 1'b0;
        word       = dout;
        if (sh) begin
            case (state)
                S_IDLE: begin
                    sr_next    = shifted;
                    cnt_next   = CW'(1);
                    state_next = S_DATA;
                end
                S_DATA: begin
                    sr_next = shifted;
                    if (bit_cnt == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
                        cnt_next   = CW'(WIDE);
                        state_next = S_PAR;
`else
                        done       = 1'b1;
                        word       = shifted;
                        cnt_next   = '0;
                        state_next = S_IDLE;
`endif
                    end else begin
                        cnt_next = bit_cnt + CW'(1);
                    end
                end
                S_PAR: begin
                    // The parity bit is not shifted in; sr already holds the full word.
`ifdef SIPO_PARITY_EN
                    done = 1'b1;
                    word = sr;
`endif
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end
                default: begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
            dout    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            sr      <= sr_next;
            bit_cnt <= cnt_next;
            if (done) begin
                dout  <= word;
                valid <= 1'b1;
                if (valid && !ack) overrun <= 1'b1;
            end else if (ack) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      par_q <= 1'b0;
        else if (sh && state == S_PAR)  par_q <= (^sr) ^ din;
    end

    assign parity_err = par_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
